lsu: RTL and testbench
======================

# lsu

Multi-cycle load/store unit sitting directly downstream of the execute stage. It replaces the core's zero-latency data-memory access with a valid/ready request channel and a response channel, so the core can run against real-latency memory. It takes the decoded load/store controls, the ALU-computed address and rs2 data, generates the lane-aligned write data and byte mask, and sign/zero-extends load data. It stalls the core until the access completes.

## Interface
- CPU_WIDTH, 32, data/address width (fixed 32; byte-lane logic assumes 4 lanes)
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_idu_lden  in  1  current instruction is a load
- i_idu_sten  in  1  current instruction is a store
- i_idu_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- i_exu_addr  in  32  byte address from ALU
- i_rs2_data  in  32  store data (unshifted)
- o_lsu_stall  out  1  core must hold PC/instruction and suppress regfile write
- o_lsu_done  out  1  one-cycle pulse: access complete, o_lsu_rdata valid for loads
- o_lsu_err  out  1  misaligned or illegal access, combinational, no memory access
- o_lsu_rdata  out  32  extended load result
- o_mem_valid  out  1  request valid
- i_mem_ready  in  1  request accepted
- o_mem_wen  out  1  1 = write, 0 = read
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_mem_wdata  out  32  lane-shifted store data
- o_mem_wmask  out  4  byte-lane write enables (0 for reads)
- i_mem_rvalid  in  1  response valid (read data or write ack)
- i_mem_rdata  in  32  read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- Request: req = lden | sten; off = addr[1:0].
- err (IDLE only): lden & sten; lden with funct3 ∉ {000,001,010,100,101}; sten with funct3 ∉ {000,001,010}; halfword with off[0]=1; word with off≠0. err → stay IDLE, no stall, no memory access, o_lsu_rdata unchanged.
- IDLE: req & !err → latch wen, funct3, off, word address, wdata, wmask; → REQ.
- Store shaping: wdata = rs2 << (8*off); wmask sb = 0001<<off, sh = 0011<<off, sw = 1111.
- REQ: o_mem_valid=1, all o_mem_* held stable from latched regs; on i_mem_ready → WAIT.
- WAIT: on i_mem_rvalid → DONE; for loads capture shifted = rdata >> (8*off), then lb/lh sign-extend bit 7/15, lbu/lhu zero-extend, lw pass-through, into o_lsu_rdata.
- DONE: o_lsu_done=1, stall=0; unconditionally → IDLE (request inputs this cycle belong to the completing instruction and are ignored).
- o_lsu_stall = (IDLE & req & !err) | REQ | WAIT.
- o_lsu_rdata updated only on load completion; stores leave it unchanged.
- i_mem_rvalid outside WAIT ignored. i_mem_ready outside REQ ignored.

## Timing
- Reset values: state IDLE, o_mem_valid 0, o_mem_wen 0, o_mem_addr 0, o_mem_wdata 0, o_mem_wmask 0, o_lsu_rdata 0, o_lsu_done 0; o_lsu_stall/o_lsu_err follow inputs combinationally.
- Reset assertion in any state drops o_mem_valid immediately (async); an in-flight response is discarded.
- Best case (ready=1 in REQ, rvalid first WAIT cycle): cycle 0 IDLE stall, cycle 1 REQ handshake, cycle 2 WAIT response, cycle 3 DONE pulse → 3 stall cycles, done at cycle 3.
- Memory must not respond in the handshake cycle; earliest rvalid is the cycle after acceptance.
- Each extra cycle of i_mem_ready=0 or i_mem_rvalid=0 adds exactly one stall cycle.
- Back-to-back accesses: DONE→IDLE, new request detected the cycle after DONE; no dead cycle beyond DONE.
- Only one outstanding transaction; no pipelining.

## Test plan
- lb, addr 0x80000003, mem word 0x80FFEE11, ready/rvalid immediate → done at cycle 3, o_lsu_rdata = 0xFFFFFF80, wmask 0, o_mem_addr 0x80000000.
- sh, addr 0x80000102, rs2 0x1234ABCD → o_mem_wdata 0xABCD0000, o_mem_wmask 0xC, o_mem_wen 1, o_lsu_rdata unchanged.
- lw at addr 0x80000001 → o_lsu_err=1, o_lsu_stall=0, o_mem_valid never asserted.
- lhu, addr 0x80000002, word 0x9ABC0000, i_mem_ready held 0 for 3 REQ cycles then rvalid delayed 2 cycles → o_mem_* stable throughout, 8 stall cycles total, o_lsu_rdata = 0x00009ABC.
- Load in WAIT, i_rst driven 0 mid-cycle → o_mem_valid 0 and state IDLE immediately; later rvalid ignored; o_lsu_rdata = 0.
- lw then sb back-to-back → second request's o_mem_valid rises exactly 2 cycles after first o_lsu_done; each instruction produces exactly one done pulse.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns decoded load/store controls into a single-outstanding
// valid/ready memory transaction and stalls the core until the response returns.
module lsu #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_idu_lden,
    input  logic                 i_idu_sten,
    input  logic [2:0]           i_idu_funct3,
    input  logic [CPU_WIDTH-1:0] i_exu_addr,
    input  logic [CPU_WIDTH-1:0] i_rs2_data,
    output logic                 o_lsu_stall,
    output logic                 o_lsu_done,
    output logic                 o_lsu_err,
    output logic [CPU_WIDTH-1:0] o_lsu_rdata,
    output logic                 o_mem_valid,
    input  logic                 i_mem_ready,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_wmask,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic       req;
    logic [1:0] off;
    logic       acc_err;
    logic       start;
    logic [2:0] funct3_q;
    logic [1:0] off_q;

    function automatic logic [CPU_WIDTH-1:0] store_data(input logic [CPU_WIDTH-1:0] rs2,
                                                        input logic [1:0] lane);
        return rs2 << {lane, 3'b000};
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Bring the addressed lane down to bit 0, then extend according to funct3.
    function automatic logic [CPU_WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [CPU_WIDTH-1:0] word);
        logic signed [CPU_WIDTH-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  return {24'd0, shifted[7:0]};
            3'b101:  return {16'd0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    assign req = i_idu_lden | i_idu_sten;
    assign off = i_exu_addr[1:0];

    always_comb begin
        acc_err = 1'b0;
        if (i_idu_lden && i_idu_sten) begin
            acc_err = 1'b1;
        end else if (i_idu_lden) begin
            case (i_idu_funct3)
                3'b000, 3'b100: acc_err = 1'b0;
                3'b001, 3'b101: acc_err = off[0];
                3'b010:         acc_err = (off != 2'b00);
                default:        acc_err = 1'b1;
            endcase
        end else if (i_idu_sten) begin
            case (i_idu_funct3)
                3'b000:  acc_err = 1'b0;
                3'b001:  acc_err = off[0];
                3'b010:  acc_err = (off != 2'b00);
                default: acc_err = 1'b1;
            endcase
        end
    end

    assign start = (state == S_IDLE) && req && !acc_err;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_mem_valid = 1'b0;
        o_lsu_done  = 1'b0;
        o_lsu_err   = 1'b0;
        o_lsu_stall = 1'b0;
        case (state)
            S_IDLE: begin
                o_lsu_err   = acc_err;
                o_lsu_stall = start;
                if (start) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_valid = 1'b1;
                o_lsu_stall = 1'b1;
                if (i_mem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                o_lsu_stall = 1'b1;
                if (i_mem_rvalid) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Inputs still describe the finishing instruction; never restart here.
                o_lsu_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wmask <= 4'b0000;
        end else if (start) begin
            o_mem_wen   <= i_idu_sten;
            o_mem_addr  <= {i_exu_addr[CPU_WIDTH-1:2], 2'b00};
            o_mem_wdata <= store_data(i_rs2_data, off);
            o_mem_wmask <= i_idu_sten ? store_mask(i_idu_funct3[1:0], off) : 4'b0000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (start) begin
            funct3_q <= i_idu_funct3;
            off_q    <= off;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_lsu_rdata <= '0;
        end else if ((state == S_WAIT) && i_mem_rvalid && !o_mem_wen) begin
            o_lsu_rdata <= load_ext(funct3_q, off_q, i_mem_rdata);
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and randomized accesses scored against a byte-level
// reference model of the load/store rules.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        lden;
    logic        sten;
    logic [2:0]  funct3;
    logic [31:0] exu_addr;
    logic [31:0] rs2_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          npass = 0;
    int          nfail = 0;
    logic [31:0] exp_rdata = 32'd0;

    lsu #(.CPU_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_idu_lden   (lden),
        .i_idu_sten   (sten),
        .i_idu_funct3 (funct3),
        .i_exu_addr   (exu_addr),
        .i_rs2_data   (rs2_data),
        .o_lsu_stall  (lsu_stall),
        .o_lsu_done   (lsu_done),
        .o_lsu_err    (lsu_err),
        .o_lsu_rdata  (lsu_rdata),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_wen    (mem_wen),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wmask  (mem_wmask),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [1:0] off);
        int size;
        if (ld && st) return 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(off) % size) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] off);
        int n;
        int m;
        n = 1 << f3[1:0];
        m = ((1 << n) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        int     n;
        longint val;
        n   = 1 << f3[1:0];
        val = 0;
        for (int i = 0; i < n; i++) begin
            val = val + (longint'(word[8*(int'(off)+i) +: 8]) << (8*i));
        end
        if (!f3[2] && val >= (64'sd1 << (8*n-1))) begin
            val = val - (64'sd1 << (8*n));
        end
        return val[31:0];
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        lden = 1'b0; sten = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("idle.stall", {31'd0, lsu_stall}, 32'd0);
        chk("idle.valid", {31'd0, mem_valid}, 32'd0);
    endtask

    // One instruction from issue to its done cycle; request inputs stay held throughout.
    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] word, input int rdly, input int vdly,
                          input string tag);
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        int          stalls;
        int          dones;
        err     = model_err(ld, st, f3, addr[1:0]);
        e_addr  = {addr[31:2], 2'b00};
        e_wdata = rs2 << (8*int'(addr[1:0]));
        e_mask  = st ? model_mask(f3, addr[1:0]) : 4'b0000;

        @(negedge clk);
        lden = ld; sten = st; funct3 = f3; exu_addr = addr; rs2_data = rs2;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1;
        chk({tag, ".err"}, {31'd0, lsu_err}, {31'd0, err});
        chk({tag, ".valid0"}, {31'd0, mem_valid}, 32'd0);
        if (err) begin
            chk({tag, ".err_stall"}, {31'd0, lsu_stall}, 32'd0);
            @(negedge clk);
            #1;
            chk({tag, ".err_novalid"}, {31'd0, mem_valid}, 32'd0);
            chk({tag, ".err_rdata"}, lsu_rdata, exp_rdata);
            return;
        end
        chk({tag, ".stall0"}, {31'd0, lsu_stall}, 32'd1);
        stalls = int'(lsu_stall);
        dones  = int'(lsu_done);

        for (int k = 0; k <= rdly; k++) begin
            @(negedge clk);
            mem_ready  = (k == rdly);
            mem_rvalid = (k < rdly) ? 1'($urandom % 2) : 1'b0;
            mem_rdata  = $urandom;
            #1;
            stalls += int'(lsu_stall);
            dones  += int'(lsu_done);
            chk({tag, ".req_valid"}, {31'd0, mem_valid}, 32'd1);
            chk({tag, ".req_wen"}, {31'd0, mem_wen}, {31'd0, st});
            chk({tag, ".req_addr"}, mem_addr, e_addr);
            chk({tag, ".req_wmask"}, {28'd0, mem_wmask}, {28'd0, e_mask});
            if (st) chk({tag, ".req_wdata"}, mem_wdata, e_wdata);
        end

        for (int k = 0; k <= vdly; k++) begin
            @(negedge clk);
            mem_rvalid = (k == vdly);
            mem_ready  = 1'($urandom % 2);
            mem_rdata  = (k == vdly) ? word : $urandom;
            #1;
            stalls += int'(lsu_stall);
            dones  += int'(lsu_done);
            chk({tag, ".wait_valid"}, {31'd0, mem_valid}, 32'd0);
        end

        @(negedge clk);
        mem_rvalid = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        if (ld) exp_rdata = model_load(f3, addr[1:0], word);
        chk({tag, ".done"}, {31'd0, lsu_done}, 32'd1);
        chk({tag, ".done_stall"}, {31'd0, lsu_stall}, 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, exp_rdata);
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(3 + rdly + vdly));
        chk({tag, ".early_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        logic        r_ld;
        logic        r_st;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;

        rst = 1'b0; lden = 1'b0; sten = 1'b0; funct3 = 3'd0; exu_addr = 32'd0;
        rs2_data = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.valid", {31'd0, mem_valid}, 32'd0);
        chk("rst.wen", {31'd0, mem_wen}, 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst.rdata", lsu_rdata, 32'd0);
        chk("rst.done", {31'd0, lsu_done}, 32'd0);
        chk("rst.stall", {31'd0, lsu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed accesses
        access(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_EE11, 0, 0, "lb");
        chk("lb.const", lsu_rdata, 32'hFFFF_FF80);
        idle_cycle();
        access(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'h1234_ABCD, 32'hDEAD_0000, 0, 0, "sh");
        idle_cycle();
        access(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0, 32'd0, 0, 0, "lw_mis");
        idle_cycle();
        access(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h9ABC_0000, 3, 2, "lhu");
        chk("lhu.const", lsu_rdata, 32'h0000_9ABC);
        idle_cycle();
        access(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 0, 0, "lw_b2b");
        access(1'b0, 1'b1, 3'b000, 32'h8000_0021, 32'h0000_00A5, 32'd0, 1, 1, "sb_b2b");
        idle_cycle();
        access(1'b1, 1'b1, 3'b000, 32'h8000_0000, 32'd0, 32'd0, 0, 0, "ldst");
        access(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'd0, 32'd0, 0, 0, "sbu_illegal");
        access(1'b1, 1'b0, 3'b110, 32'h8000_0000, 32'd0, 32'd0, 0, 0, "ld_illegal");
        idle_cycle();

        // Reset while a load waits for its response
        @(negedge clk);
        lden = 1'b1; sten = 1'b0; funct3 = 3'b010; exu_addr = 32'h8000_0040;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("arst.wait_stall", {31'd0, lsu_stall}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.valid", {31'd0, mem_valid}, 32'd0);
        chk("arst.addr", mem_addr, 32'd0);
        chk("arst.rdata", lsu_rdata, 32'd0);
        chk("arst.done", {31'd0, lsu_done}, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b1; lden = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("arst.late_done", {31'd0, lsu_done}, 32'd0);
        chk("arst.late_rdata", lsu_rdata, 32'd0);
        chk("arst.late_valid", {31'd0, mem_valid}, 32'd0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            r_ld   = 1'($urandom % 2);
            r_st   = r_ld ? ($urandom % 8 == 0) : 1'b1;
            r_f3   = 3'($urandom % 8);
            r_addr = $urandom;
            if ($urandom % 3 != 0) r_addr[1:0] = r_addr[1:0] & ~2'((1 << r_f3[1:0]) - 1);
            access(r_ld, r_st, r_f3, r_addr, $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % 4), "rnd");
            if ($urandom % 2 == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

endmodule
